// File: rtl/psg_pkg.sv
// Shared definitions for the PSG write arbiter slice.
//   - register codes as they appear in the PSG latch byte (bits 6:4)
//   - field widths for tone period, attenuation and noise control
//   - arbiter FSM state encoding
//   - is_two_byte(): tone registers need a latch byte plus a data byte
package psg_pkg;

  localparam int FREQ_BITS  = 10;
  localparam int ATTN_BITS  = 4;
  localparam int NOISE_BITS = 3;

  localparam logic [2:0] REG_TONE0 = 3'b000;
  localparam logic [2:0] REG_ATTN0 = 3'b001;
  localparam logic [2:0] REG_TONE1 = 3'b010;
  localparam logic [2:0] REG_ATTN1 = 3'b011;
  localparam logic [2:0] REG_TONE2 = 3'b100;
  localparam logic [2:0] REG_ATTN2 = 3'b101;
  localparam logic [2:0] REG_NOISE = 3'b110;
  localparam logic [2:0] REG_ATTN3 = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_GAP_A = 3'd2,
    ST_DATA  = 3'd3,
    ST_GAP_B = 3'd4
  } psg_state_e;

  // Tone registers are the even codes except noise; only they carry
  // more than four value bits and therefore a second (data) byte.
  function automatic logic is_two_byte(input logic [2:0] reg_code);
    return (reg_code[0] == 1'b0) && (reg_code != REG_NOISE);
  endfunction

endpackage

// File: rtl/psg_write_arbiter_if.sv
// One requester's command channel into the PSG write arbiter.
//   valid    : requester has a command (master -> slave)
//   ready    : arbiter accepts the command this cycle (slave -> master)
//   reg_code : 3-bit PSG register code
//   value    : 10-bit register value (only the bits the register uses matter)
// Handshake: a command transfers in a cycle where valid & ready are both 1.
// The master holds valid, reg_code and value stable until that cycle; ready
// is combinational and may be 0 while valid is 1 for any number of cycles.
interface psg_write_arbiter_if;
  import psg_pkg::*;

  logic                 valid;
  logic                 ready;
  logic [2:0]           reg_code;
  logic [FREQ_BITS-1:0] value;

  modport master (output valid, output reg_code, output value, input ready);
  modport slave  (input valid, input reg_code, input value, output ready);

endinterface

// File: rtl/psg_byte_encoder.sv
// Turns a whole-register command into the PSG bus bytes.
//   reg_code   : register code
//   value      : register value
//   latch_byte : {1, reg_code, low nibble}; noise keeps only 3 value bits
//   data_byte  : {00, value[9:4]} (meaningful for tone registers only)
//   two_byte   : 1 when the data byte must follow the latch byte
module psg_byte_encoder
  import psg_pkg::*;
(
  input  logic [2:0]           reg_code,
  input  logic [FREQ_BITS-1:0] value,
  output logic [7:0]           latch_byte,
  output logic [7:0]           data_byte,
  output logic                 two_byte
);

  logic [3:0] low_nibble;

  always_comb begin
    // Unused value bits are masked so they never reach the PSG.
    if (reg_code == REG_NOISE) begin
      low_nibble = {1'b0, value[NOISE_BITS-1:0]};
    end else begin
      low_nibble = value[ATTN_BITS-1:0];
    end
    latch_byte = {1'b1, reg_code, low_nibble};
    data_byte  = {2'b00, value[FREQ_BITS-1:ATTN_BITS]};
    two_byte   = is_two_byte(reg_code);
  end

endmodule

// File: rtl/psg_write_arbiter.sv
// Round-robin arbiter sharing the PSG write port between two requesters.
//   clk, reset : clock, synchronous active-high reset
//   req0, req1 : command channels (slave side)
//   psg_data   : registered byte to the PSG
//   psg_we_n   : registered active-low write strobe, one cycle per byte
//   busy       : 1 whenever the FSM is not IDLE
//   state_dbg  : current FSM state
// Commands are accepted only in IDLE, so the latch and data bytes of a tone
// write always reach the PSG back to back with nothing in between.
module psg_write_arbiter
  import psg_pkg::*;
#(
  parameter int GAP_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  psg_write_arbiter_if.slave        req0,
  psg_write_arbiter_if.slave        req1,
  output logic [7:0]                psg_data,
  output logic                      psg_we_n,
  output logic                      busy,
  output psg_state_e                state_dbg
);

  localparam logic [3:0] GAP_N    = GAP_CYCLES[3:0];
  localparam logic [3:0] GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : GAP_N - 4'd1;

  psg_state_e           state;
  psg_state_e           state_next;
  logic                 prefer1;     // 1: req1 wins a tie
  logic                 grant0;
  logic                 grant1;
  logic                 handshake;
  logic [2:0]           cap_reg;
  logic [FREQ_BITS-1:0] cap_value;
  logic [3:0]           gap_cnt;
  logic                 gap_done;

  logic [2:0]           enc_reg;
  logic [FREQ_BITS-1:0] enc_value;
  logic [7:0]           latch_byte;
  logic [7:0]           data_byte;
  logic                 two_byte;

  // Arbitration: only in IDLE and never while reset is asserted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset && state == ST_IDLE) begin
      if (req0.valid && (!req1.valid || !prefer1)) begin
        grant0 = 1'b1;
      end else if (req1.valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0.ready = grant0;
  assign req1.ready = grant1;
  assign handshake  = grant0 | grant1;

  // The latch byte is registered in the handshake cycle, before the command
  // is captured, so the encoder looks at the winner directly then.
  always_comb begin
    enc_reg   = cap_reg;
    enc_value = cap_value;
    if (grant0) begin
      enc_reg   = req0.reg_code;
      enc_value = req0.value;
    end else if (grant1) begin
      enc_reg   = req1.reg_code;
      enc_value = req1.value;
    end
  end

  psg_byte_encoder u_encoder (
    .reg_code   (enc_reg),
    .value      (enc_value),
    .latch_byte (latch_byte),
    .data_byte  (data_byte),
    .two_byte   (two_byte)
  );

  assign gap_done = (gap_cnt == GAP_LAST);

  // Next-state logic. With no gap configured the GAP states are bypassed.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (handshake) state_next = ST_LATCH;
      end
      ST_LATCH: begin
        if (GAP_N != 4'd0) state_next = ST_GAP_A;
        else if (two_byte) state_next = ST_DATA;
        else               state_next = ST_IDLE;
      end
      ST_GAP_A: begin
        if (gap_done) state_next = two_byte ? ST_DATA : ST_IDLE;
      end
      ST_DATA: begin
        state_next = (GAP_N != 4'd0) ? ST_GAP_B : ST_IDLE;
      end
      ST_GAP_B: begin
        if (gap_done) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      prefer1   <= 1'b0;
      cap_reg   <= 3'd0;
      cap_value <= '0;
      gap_cnt   <= 4'd0;
      psg_data  <= 8'h00;
      psg_we_n  <= 1'b1;
    end else begin
      state <= state_next;
      if (handshake) begin
        cap_reg   <= enc_reg;
        cap_value <= enc_value;
        prefer1   <= grant0;
      end
      // Counts cycles spent in the current gap state; restarts on entry.
      if ((state == ST_GAP_A || state == ST_GAP_B) && state_next == state) begin
        gap_cnt <= gap_cnt + 4'd1;
      end else begin
        gap_cnt <= 4'd0;
      end
      // Outputs are driven from the state being entered so they line up
      // with LATCH/DATA being the current state.
      psg_we_n <= !(state_next == ST_LATCH || state_next == ST_DATA);
      if (state_next == ST_LATCH) begin
        psg_data <= latch_byte;
      end else if (state_next == ST_DATA) begin
        psg_data <= data_byte;
      end
    end
  end

  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_psg_write_arbiter.sv
// Bench for psg_write_arbiter: one instance with one gap cycle (index 0) and
// one with no gap (index 1), each with its own two requesters.
module tb_psg_write_arbiter;
  import psg_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  psg_write_arbiter_if a0 ();
  psg_write_arbiter_if a1 ();
  psg_write_arbiter_if b0 ();
  psg_write_arbiter_if b1 ();

  logic       in_v   [2][2];
  logic [2:0] in_r   [2][2];
  logic [9:0] in_val [2][2];
  logic       o_rdy  [2][2];
  logic [7:0] o_data [2];
  logic       o_we   [2];
  logic       o_busy [2];
  psg_state_e st_a;
  psg_state_e st_b;

  assign a0.valid = in_v[0][0];  assign a0.reg_code = in_r[0][0];  assign a0.value = in_val[0][0];
  assign a1.valid = in_v[0][1];  assign a1.reg_code = in_r[0][1];  assign a1.value = in_val[0][1];
  assign b0.valid = in_v[1][0];  assign b0.reg_code = in_r[1][0];  assign b0.value = in_val[1][0];
  assign b1.valid = in_v[1][1];  assign b1.reg_code = in_r[1][1];  assign b1.value = in_val[1][1];
  assign o_rdy[0][0] = a0.ready;
  assign o_rdy[0][1] = a1.ready;
  assign o_rdy[1][0] = b0.ready;
  assign o_rdy[1][1] = b1.ready;

  psg_write_arbiter #(.GAP_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset), .req0(a0), .req1(a1),
    .psg_data(o_data[0]), .psg_we_n(o_we[0]), .busy(o_busy[0]), .state_dbg(st_a)
  );

  psg_write_arbiter #(.GAP_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .req0(b0), .req1(b1),
    .psg_data(o_data[1]), .psg_we_n(o_we[1]), .busy(o_busy[1]), .state_dbg(st_b)
  );

  // ---------------- reference model state ----------------
  int          cyc;
  int          free_at   [2];   // first cycle the instance can accept again
  bit          pref1     [2];
  logic [7:0]  last_byte [2];
  logic [39:0] exp_q     [2][$]; // {cycle, byte} of every expected strobe
  bit          hs        [2][2];
  bit          check_en;
  bit          auto_mode;
  bit          keep_valid;
  int          n_tests;
  int          n_fail;

  function automatic int gap_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  function automatic bit is_tone(input logic [2:0] r);
    return (r == 3'd0) || (r == 3'd2) || (r == 3'd4);
  endfunction

  function automatic logic [7:0] exp_latch(input logic [2:0] r, input logic [9:0] v);
    int lo;
    lo = (r == 3'd6) ? int'(v) % 8 : int'(v) % 16;
    return 8'(128 + int'(r) * 16 + lo);
  endfunction

  function automatic logic [7:0] exp_data(input logic [9:0] v);
    return 8'(int'(v) / 16);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Compare one cycle of both instances against the model, then record
  // whatever handshake the model says happens this cycle.
  task automatic check_cycle();
    int          w;
    int          g;
    logic        e_we;
    logic [7:0]  e_data;
    logic [39:0] ent;
    logic [2:0]  r;
    logic [9:0]  v;
    for (int d = 0; d < 2; d++) begin
      g = gap_of(d);
      w = -1;
      if (!reset && cyc >= free_at[d]) begin
        if (in_v[d][0] && in_v[d][1]) w = pref1[d] ? 1 : 0;
        else if (in_v[d][0])          w = 0;
        else if (in_v[d][1])          w = 1;
      end
      e_we   = 1'b1;
      e_data = last_byte[d];
      if (exp_q[d].size() > 0) begin
        ent = exp_q[d][0];
        if (int'(ent[39:8]) == cyc) begin
          ent          = exp_q[d].pop_front();
          e_we         = 1'b0;
          e_data       = ent[7:0];
          last_byte[d] = ent[7:0];
        end
      end
      if (check_en) begin
        check($sformatf("d%0d_ready0", d), 32'(o_rdy[d][0]), 32'(w == 0));
        check($sformatf("d%0d_ready1", d), 32'(o_rdy[d][1]), 32'(w == 1));
        check($sformatf("d%0d_we_n", d),   32'(o_we[d]),     32'(e_we));
        check($sformatf("d%0d_data", d),   32'(o_data[d]),   32'(e_data));
        check($sformatf("d%0d_busy", d),   32'(o_busy[d]),   32'(cyc < free_at[d]));
      end
      hs[d][0] = (w == 0);
      hs[d][1] = (w == 1);
      if (w >= 0) begin
        pref1[d] = (w == 0);
        r = in_r[d][w];
        v = in_val[d][w];
        exp_q[d].push_back({32'(cyc + 1), exp_latch(r, v)});
        if (is_tone(r)) begin
          exp_q[d].push_back({32'(cyc + 2 + g), exp_data(v)});
          free_at[d] = cyc + 1 + 2 + 2 * g;
        end else begin
          free_at[d] = cyc + 1 + 1 + g;
        end
      end
    end
  endtask

  task automatic model_clock();
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        exp_q[d].delete();
        last_byte[d] = 8'h00;
        pref1[d]     = 1'b0;
        free_at[d]   = cyc + 1;
      end
    end
    cyc++;
  endtask

  task automatic new_cmd(input int d, input int i);
    in_v[d][i]   = 1'b1;
    in_r[d][i]   = 3'($urandom_range(0, 7));
    in_val[d][i] = 10'($urandom_range(0, 1023));
  endtask

  task automatic drive_next();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 2; i++) begin
        if (auto_mode) begin
          if (in_v[d][i] && hs[d][i]) begin
            if ($urandom_range(0, 1) == 0) in_v[d][i] = 1'b0;
            else                           new_cmd(d, i);
          end else if (!in_v[d][i] && $urandom_range(0, 2) == 0) begin
            new_cmd(d, i);
          end
        end else if (hs[d][i] && !keep_valid) begin
          in_v[d][i] = 1'b0;
        end
      end
    end
    if (auto_mode) reset = ($urandom_range(0, 299) == 0);
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    model_clock();
    #1;
    drive_next();
  endtask

  task automatic set_req(input int i, input logic [2:0] r, input logic [9:0] v);
    for (int d = 0; d < 2; d++) begin
      in_v[d][i]   = 1'b1;
      in_r[d][i]   = r;
      in_val[d][i] = v;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    bit found;
    n_tests    = 0;
    n_fail     = 0;
    cyc        = 0;
    check_en   = 1'b0;
    auto_mode  = 1'b0;
    keep_valid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      free_at[d]   = 0;
      pref1[d]     = 1'b0;
      last_byte[d] = 8'h00;
      for (int i = 0; i < 2; i++) begin
        in_v[d][i]   = 1'b0;
        in_r[d][i]   = 3'd0;
        in_val[d][i] = 10'd0;
        hs[d][i]     = 1'b0;
      end
    end
    reset = 1'b1;
    // A valid present during reset must not be accepted.
    set_req(0, 3'b000, 10'h3FE);
    step();
    check_en = 1'b1;
    step();
    reset = 1'b0;

    // Single tone on req0: 8E then 3F (gap 1) / consecutive (gap 0).
    run(8);
    // Attenuation on req1: D5, single byte.
    set_req(1, 3'b101, 10'h005);
    run(6);
    // Noise on req0: E4, upper value bits dropped.
    set_req(0, 3'b110, 10'h3FC);
    run(6);

    // Contention with tone pairs held continuously.
    keep_valid = 1'b1;
    set_req(0, 3'b010, 10'h123);
    set_req(1, 3'b100, 10'h0F0);
    run(24);

    // Reset in the very cycle a latch byte strobes on the gap-1 instance.
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (exp_q[0].size() > 0 && int'(exp_q[0][0][39:8]) == cyc && exp_q[0][0][7]) begin
        found = 1'b1;
      end else begin
        step();
      end
    end
    check("latch_found", 32'(found), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    run(12);
    keep_valid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_v[d][0] = 1'b0;
      in_v[d][1] = 1'b0;
    end
    run(8);

    // Randomised traffic with occasional resets.
    auto_mode = 1'b1;
    run(3000);
    auto_mode = 1'b0;
    reset     = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_v[d][0] = 1'b0;
      in_v[d][1] = 1'b0;
    end
    run(20);
    check("drain_a", 32'(exp_q[0].size()), 32'd0);
    check("drain_b", 32'(exp_q[1].size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
